// File: rtl/writeback_buffer.sv
// In-order result queue feeding the single register-file write port.
// Drops x0 writes, drains one entry per cycle, and flags pending writes for decode.
module writeback_buffer #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_dest,
  input  logic [XLEN-1:0]            in_data,
  output logic                       rf_write_enable,
  output logic [ADDR_W-1:0]          rf_dest,
  output logic [XLEN-1:0]            rf_data_in,
  input  logic [ADDR_W-1:0]          src_one,
  input  logic [ADDR_W-1:0]          src_two,
  output logic                       hazard_one,
  output logic                       hazard_two,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_hit_one;
  logic w_hit_two;

  assign w_nonempty = (r_count != {CNT_W{1'b0}});
  assign w_in_ready = !reset && !flush && (r_count < CNT_W'(DEPTH));
  // x0 results complete the handshake but are never stored
  assign w_push     = in_valid && w_in_ready && (in_dest != {ADDR_W{1'b0}});
  // The register file never back-pressures, so the head leaves every cycle it exists
  assign w_pop      = w_nonempty;

  assign in_ready        = w_in_ready;
  assign count           = r_count;
  assign rf_write_enable = !reset && w_nonempty;
  assign rf_dest         = rf_write_enable ? r_dest[r_rd_ptr] : {ADDR_W{1'b0}};
  assign rf_data_in      = rf_write_enable ? r_data[r_rd_ptr] : {XLEN{1'b0}};
  assign hazard_one      = !reset && (src_one != {ADDR_W{1'b0}}) && w_hit_one;
  assign hazard_two      = !reset && (src_two != {ADDR_W{1'b0}}) && w_hit_two;

  // Entry i is occupied when its distance from the read pointer is below count
  always_comb begin
    logic [PTR_W-1:0] v_off;
    v_off     = {PTR_W{1'b0}};
    w_hit_one = 1'b0;
    w_hit_two = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = PTR_W'(i) - r_rd_ptr;
      if ({1'b0, v_off} < r_count) begin
        if (r_dest[i] == src_one) begin
          w_hit_one = 1'b1;
        end else begin
          w_hit_one = w_hit_one;
        end
        if (r_dest[i] == src_two) begin
          w_hit_two = 1'b1;
        end else begin
          w_hit_two = w_hit_two;
        end
      end else begin
        w_hit_one = w_hit_one;
        w_hit_two = w_hit_two;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_dest[r_wr_ptr] <= in_dest;
        r_data[r_wr_ptr] <= in_data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
